// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE/SHA3 pad10*1 padder.
package shake_pkg;

   localparam int unsigned LaneW = 64;

   localparam logic [4:0] RATE_LANES_SHAKE128 = 5'd21;
   localparam logic [4:0] RATE_LANES_SHAKE256 = 5'd17;
   localparam logic [4:0] RATE_LANES_SHA3_256 = 5'd17;
   localparam logic [4:0] RATE_LANES_SHA3_512 = 5'd9;

   localparam logic [7:0] DS_SHAKE = 8'h1F;
   localparam logic [7:0] DS_SHA3  = 8'h06;

   typedef enum logic [1:0] {
      ModeShake128 = 2'b00,
      ModeShake256 = 2'b01,
      ModeSha3x256 = 2'b10,
      ModeSha3x512 = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      StIdle,
      StAbsorb,
      StPadDs,
      StPadZero
   } state_e;

endpackage

// File: rtl/shake_pad_lane.sv
// Combinational lane former: keeps the low k bytes, drops the DS byte at byte k,
// zeroes the rest, and optionally sets the closing 0x80 bit in byte 7.
module shake_pad_lane
   import shake_pkg::*;
(
   input  logic [LaneW-1:0] data,
   input  logic [3:0]       k,
   input  logic             ds_en,
   input  logic [7:0]       ds,
   input  logic             final_en,
   output logic [LaneW-1:0] lane
);

   logic [3:0] k_eff;

   always_comb begin
      k_eff = (k > 4'd8) ? 4'd8 : k;
      lane  = data;
      if (ds_en) begin
         for (int i = 0; i < 8; i++) begin
            if (4'(i) == k_eff) begin
               lane[8*i +: 8] = ds;
            end else if (4'(i) > k_eff) begin
               lane[8*i +: 8] = 8'h00;
            end
         end
      end
      if (final_en) begin
         lane[63:56] = lane[63:56] | 8'h80;
      end
   end

endmodule

// File: rtl/shake_padder.sv
// Streaming pad10*1 stage ahead of the Keccak absorb datapath.
// Define SHAKE_PADDER_SHA3_EN to add the SHA3-256/SHA3-512 modes.
module shake_padder
   import shake_pkg::*;
#(
   parameter int unsigned W = LaneW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   mode,
   input  logic [W-1:0] in_data,
   input  logic [3:0]   in_bytes,
   input  logic         in_last,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_block_last,
   output logic         out_msg_last,
   output logic         busy
);

   state_e     state_q, state_d;
   logic [4:0] lane_cnt_q, lane_cnt_d;
   mode_e      mode_q, mode_d;

   logic [4:0]   rate;
   logic [7:0]   ds;
   logic         at_top;
   logic         k_full;
   logic         hs;
   logic [W-1:0] lane_data;
   logic [W-1:0] lane_out;
   logic [3:0]   lane_k;
   logic         lane_ds_en;
   logic         lane_final;

   always_comb begin
      rate = RATE_LANES_SHAKE128;
      ds   = DS_SHAKE;
`ifdef SHAKE_PADDER_SHA3_EN
      unique case (mode_q)
         ModeShake128: begin rate = RATE_LANES_SHAKE128; ds = DS_SHAKE; end
         ModeShake256: begin rate = RATE_LANES_SHAKE256; ds = DS_SHAKE; end
         ModeSha3x256: begin rate = RATE_LANES_SHA3_256; ds = DS_SHA3;  end
         ModeSha3x512: begin rate = RATE_LANES_SHA3_512; ds = DS_SHA3;  end
         default:      begin rate = RATE_LANES_SHAKE128; ds = DS_SHAKE; end
      endcase
`else
      // Only mode[0] matters here; the upper bit aliases onto the SHAKE rows.
      unique case (mode_q)
         ModeShake128, ModeSha3x256: rate = RATE_LANES_SHAKE128;
         ModeShake256, ModeSha3x512: rate = RATE_LANES_SHAKE256;
         default:                    rate = RATE_LANES_SHAKE128;
      endcase
`endif
   end

   always_comb begin
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      lane_data  = '0;
      lane_k     = 4'd0;
      lane_ds_en = 1'b0;
      lane_final = 1'b0;
      at_top     = (lane_cnt_q == rate - 5'd1);
      k_full     = (in_bytes >= 4'd8);
      case (state_q)
         StAbsorb: begin
            out_valid  = in_valid;
            in_ready   = out_ready;
            lane_data  = in_data;
            lane_k     = in_bytes;
            lane_ds_en = in_last;
            lane_final = in_last && !k_full && at_top;
         end
         StPadDs: begin
            out_valid  = 1'b1;
            lane_ds_en = 1'b1;
            lane_final = at_top;
         end
         StPadZero: begin
            out_valid  = 1'b1;
            lane_final = at_top;
         end
         default: ;
      endcase
   end

   shake_pad_lane u_lane (
      .data     (lane_data),
      .k        (lane_k),
      .ds_en    (lane_ds_en),
      .ds       (ds),
      .final_en (lane_final),
      .lane     (lane_out)
   );

   assign hs             = out_valid && out_ready;
   assign out_data       = lane_out;
   assign out_block_last = at_top && out_valid;
   assign out_msg_last   = lane_final && out_valid;
   assign busy           = (state_q != StIdle);

   always_comb begin
      state_d    = state_q;
      lane_cnt_d = lane_cnt_q;
      mode_d     = mode_q;
      if (hs) begin
         lane_cnt_d = at_top ? 5'd0 : lane_cnt_q + 5'd1;
      end
      case (state_q)
         StIdle: begin
            if (start) begin
               mode_d     = mode_e'(mode);
               lane_cnt_d = 5'd0;
               state_d    = StAbsorb;
            end
         end
         StAbsorb: begin
            if (hs && in_last) begin
               if (lane_final)  state_d = StIdle;
               else if (k_full) state_d = StPadDs;
               else             state_d = StPadZero;
            end
         end
         StPadDs: begin
            if (hs) state_d = lane_final ? StIdle : StPadZero;
         end
         StPadZero: begin
            if (hs && lane_final) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         lane_cnt_q <= 5'd0;
         mode_q     <= ModeShake128;
      end else begin
         state_q    <= state_d;
         lane_cnt_q <= lane_cnt_d;
         mode_q     <= mode_d;
      end
   end

endmodule

// File: tb/tb_shake_padder.sv
// Directed self-checking bench for shake_padder; SHA3 case runs when
// SHAKE_PADDER_SHA3_EN is defined.
module tb_shake_padder;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  mode;
   logic [63:0] in_data;
   logic [3:0]  in_bytes;
   logic        in_last;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_block_last;
   logic        out_msg_last;
   logic        busy;

   int n_checks;
   int n_fails;

   logic [63:0] msg_words [0:63];
   logic        rdy_pat   [0:3];
   int          rdy_len;

   logic [63:0] cap_data [0:63];
   logic        cap_bl   [0:63];
   logic        cap_ml   [0:63];
   int          cap_n;
   logic        cap_done;
   logic        busy_after;
   int          stall_changes;
   int          mirror_err;

   shake_padder dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .mode           (mode),
      .in_data        (in_data),
      .in_bytes       (in_bytes),
      .in_last        (in_last),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_block_last (out_block_last),
      .out_msg_last   (out_msg_last),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Entered at a negedge; pulses start, feeds nwords words and records every
   // output handshake until the message-last lane or the cycle budget runs out.
   task automatic run_msg(input logic [1:0] m, input int nwords, input logic [3:0] lastb,
                          input int budget);
      int          wi;
      logic        stalled;
      logic [63:0] held_d;
      logic        held_bl;
      logic        held_ml;
      wi = 0; stalled = 1'b0; held_d = '0; held_bl = 1'b0; held_ml = 1'b0;
      cap_n = 0; cap_done = 1'b0; stall_changes = 0; mirror_err = 0; busy_after = 1'bx;
      for (int i = 0; i < 64; i++) begin
         cap_data[i] = 'x; cap_bl[i] = 1'bx; cap_ml[i] = 1'bx;
      end
      start = 1'b1; mode = m;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < budget; c++) begin
         out_ready = rdy_pat[c % rdy_len];
         in_valid  = (wi < nwords);
         in_data   = (wi < nwords) ? msg_words[wi] : '0;
         in_last   = (wi == nwords - 1);
         in_bytes  = lastb;
         #1;
         if (wi < nwords && in_ready !== out_ready) mirror_err++;
         if (stalled && (out_data !== held_d || out_block_last !== held_bl ||
                         out_msg_last !== held_ml)) stall_changes++;
         stalled = out_valid && !out_ready;
         held_d  = out_data; held_bl = out_block_last; held_ml = out_msg_last;
         if (out_valid && out_ready) begin
            cap_data[cap_n] = out_data;
            cap_bl[cap_n]   = out_block_last;
            cap_ml[cap_n]   = out_msg_last;
            cap_n++;
            if (in_valid && in_ready) wi++;
            if (out_msg_last) cap_done = 1'b1;
         end
         @(negedge clk);
         if (cap_done) break;
      end
      in_valid = 1'b0; in_last = 1'b0;
      #1;
      busy_after = busy;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; mode = 2'b00; in_data = 64'hFFFF_FFFF_FFFF_FFFF;
      in_bytes = 4'd0; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      #3;
      n_checks++; if (in_ready !== 1'b0) begin n_fails++;
         $display("FAIL reset_in_ready got %b want 0", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fails++;
         $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++; if (out_data !== 64'h0) begin n_fails++;
         $display("FAIL reset_out_data got %h want 0", out_data); end
      n_checks++; if (out_block_last !== 1'b0 || out_msg_last !== 1'b0) begin n_fails++;
         $display("FAIL reset_flags got %b%b want 00", out_block_last, out_msg_last); end
      n_checks++; if (busy !== 1'b0) begin n_fails++;
         $display("FAIL reset_busy got %b want 0", busy); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fails++;
         $display("FAIL idle_ignores_in got rdy=%b vld=%b busy=%b want 000",
                  in_ready, out_valid, busy); end
      in_valid = 1'b0; in_last = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_shake128_empty();
      logic [63:0] exp;
      rdy_pat[0] = 1'b1; rdy_len = 1;
      msg_words[0] = 64'hDEAD_BEEF_CAFE_F00D;
      run_msg(2'b00, 1, 4'd0, 40);
      n_checks++; if (cap_done !== 1'b1 || cap_n !== 21) begin n_fails++;
         $display("FAIL s128_empty_count got done=%b n=%0d want 1 21", cap_done, cap_n); end
      for (int i = 0; i < 21; i++) begin
         exp = (i == 0) ? 64'h1F : (i == 20) ? 64'h8000_0000_0000_0000 : 64'h0;
         n_checks++; if (cap_data[i] !== exp) begin n_fails++;
            $display("FAIL s128_empty_lane%0d got %h want %h", i, cap_data[i], exp); end
         n_checks++; if (cap_bl[i] !== (i == 20) || cap_ml[i] !== (i == 20)) begin n_fails++;
            $display("FAIL s128_empty_flags%0d got bl=%b ml=%b", i, cap_bl[i], cap_ml[i]); end
      end
      n_checks++; if (busy_after !== 1'b0) begin n_fails++;
         $display("FAIL s128_empty_busy_after got %b want 0", busy_after); end
   endtask

   task automatic test_full_block();
      logic [63:0] exp;
      rdy_pat[0] = 1'b1; rdy_len = 1;
      for (int i = 0; i < 17; i++) msg_words[i] = {32'hC0DE_0000 + i, 32'h5A5A_0000 + i};
      run_msg(2'b01, 17, 4'd8, 60);
      n_checks++; if (cap_done !== 1'b1 || cap_n !== 34) begin n_fails++;
         $display("FAIL s256_full_count got done=%b n=%0d want 1 34", cap_done, cap_n); end
      for (int i = 0; i < 34; i++) begin
         if (i < 17) exp = {32'hC0DE_0000 + i, 32'h5A5A_0000 + i};
         else if (i == 17) exp = 64'h1F;
         else if (i == 33) exp = 64'h8000_0000_0000_0000;
         else exp = 64'h0;
         n_checks++; if (cap_data[i] !== exp) begin n_fails++;
            $display("FAIL s256_full_lane%0d got %h want %h", i, cap_data[i], exp); end
         n_checks++; if (cap_bl[i] !== (i == 16 || i == 33) || cap_ml[i] !== (i == 33)) begin
            n_fails++;
            $display("FAIL s256_full_flags%0d got bl=%b ml=%b", i, cap_bl[i], cap_ml[i]); end
      end
   endtask

   task automatic test_ds_final_byte();
      rdy_pat[0] = 1'b1; rdy_len = 1;
      for (int i = 0; i < 16; i++) msg_words[i] = 64'h0101_0101_0101_0101 * (i + 1);
      msg_words[16] = 64'h1122_3344_5566_7788;
      run_msg(2'b01, 17, 4'd7, 40);
      n_checks++; if (cap_done !== 1'b1 || cap_n !== 17) begin n_fails++;
         $display("FAIL ds_b7_count got done=%b n=%0d want 1 17", cap_done, cap_n); end
      n_checks++; if (cap_data[16] !== 64'h9F22_3344_5566_7788) begin n_fails++;
         $display("FAIL ds_b7_lane16 got %h want 9f22334455667788", cap_data[16]); end
      n_checks++; if (cap_ml[16] !== 1'b1 || cap_bl[16] !== 1'b1 || cap_ml[15] !== 1'b0) begin
         n_fails++;
         $display("FAIL ds_b7_flags got ml16=%b bl16=%b ml15=%b want 1 1 0",
                  cap_ml[16], cap_bl[16], cap_ml[15]); end
      n_checks++; if (cap_data[5] !== 64'h0606_0606_0606_0606) begin n_fails++;
         $display("FAIL ds_b7_lane5 got %h want 0606060606060606", cap_data[5]); end
   endtask

   task automatic test_backpressure();
      logic [63:0] exp;
      rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b1; rdy_pat[3] = 1'b0; rdy_len = 4;
      msg_words[0] = 64'h1111_2222_3333_4444;
      msg_words[1] = 64'h5555_6666_7777_8888;
      msg_words[2] = 64'h0123_4567_89AB_CDEF;
      run_msg(2'b00, 3, 4'd5, 80);
      n_checks++; if (cap_done !== 1'b1 || cap_n !== 21) begin n_fails++;
         $display("FAIL bp_count got done=%b n=%0d want 1 21", cap_done, cap_n); end
      for (int i = 0; i < 21; i++) begin
         case (i)
            0:       exp = 64'h1111_2222_3333_4444;
            1:       exp = 64'h5555_6666_7777_8888;
            2:       exp = 64'h0000_1F67_89AB_CDEF;
            20:      exp = 64'h8000_0000_0000_0000;
            default: exp = 64'h0;
         endcase
         n_checks++; if (cap_data[i] !== exp) begin n_fails++;
            $display("FAIL bp_lane%0d got %h want %h", i, cap_data[i], exp); end
      end
      n_checks++; if (stall_changes !== 0) begin n_fails++;
         $display("FAIL bp_stall_stable got %0d changes want 0", stall_changes); end
      n_checks++; if (mirror_err !== 0) begin n_fails++;
         $display("FAIL bp_in_ready_mirror got %0d errors want 0", mirror_err); end
      rdy_pat[0] = 1'b1; rdy_len = 1;
   endtask

   task automatic test_reset_mid();
      start = 1'b1; mode = 2'b00; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1; in_last = 1'b1; in_bytes = 4'd0; in_data = '0;
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fails++;
         $display("FAIL rmid_pre got vld=%b busy=%b want 1 1", out_valid, busy); end
      rst = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 ||
                      out_data !== 64'h0 || out_block_last !== 1'b0 ||
                      out_msg_last !== 1'b0) begin
         n_fails++;
         $display("FAIL rmid_drop got vld=%b busy=%b rdy=%b data=%h bl=%b ml=%b want all 0",
                  out_valid, busy, in_ready, out_data, out_block_last, out_msg_last); end
      @(negedge clk);
      rst = 1'b0;
      rdy_pat[0] = 1'b1; rdy_len = 1;
      msg_words[0] = 64'h7777_0000_0000_BEEF;
      run_msg(2'b00, 1, 4'd2, 40);
      n_checks++; if (cap_n !== 21 || cap_data[0] !== 64'h0000_0000_001F_BEEF) begin
         n_fails++;
         $display("FAIL rmid_next got n=%0d lane0=%h want 21 1fbeef", cap_n, cap_data[0]); end
      n_checks++; if (cap_data[20] !== 64'h8000_0000_0000_0000 || cap_ml[20] !== 1'b1) begin
         n_fails++;
         $display("FAIL rmid_final got %h ml=%b want 8000000000000000 1",
                  cap_data[20], cap_ml[20]); end
   endtask

   task automatic test_clamp();
      rdy_pat[0] = 1'b1; rdy_len = 1;
      msg_words[0] = 64'hFEDC_BA98_7654_3210;
      run_msg(2'b00, 1, 4'd12, 40);
      n_checks++; if (cap_n !== 21 || cap_data[0] !== 64'hFEDC_BA98_7654_3210) begin
         n_fails++;
         $display("FAIL clamp_lane0 got n=%0d %h want 21 fedcba9876543210", cap_n, cap_data[0]); end
      n_checks++; if (cap_data[1] !== 64'h1F || cap_data[20] !== 64'h8000_0000_0000_0000) begin
         n_fails++;
         $display("FAIL clamp_pad got l1=%h l20=%h want 1f 8000000000000000",
                  cap_data[1], cap_data[20]); end
   endtask

   task automatic test_back_to_back();
      rdy_pat[0] = 1'b1; rdy_len = 1;
      msg_words[0] = 64'h0;
      run_msg(2'b00, 1, 4'd0, 40);
      n_checks++; if (cap_n !== 21 || busy_after !== 1'b0) begin n_fails++;
         $display("FAIL b2b_first got n=%0d busy=%b want 21 0", cap_n, busy_after); end
      run_msg(2'b01, 1, 4'd0, 40);
      n_checks++; if (cap_n !== 17 || cap_data[0] !== 64'h1F) begin n_fails++;
         $display("FAIL b2b_second got n=%0d lane0=%h want 17 1f", cap_n, cap_data[0]); end
      n_checks++; if (cap_data[16] !== 64'h8000_0000_0000_0000 || cap_ml[16] !== 1'b1) begin
         n_fails++;
         $display("FAIL b2b_second_final got %h ml=%b", cap_data[16], cap_ml[16]); end
   endtask

`ifdef SHAKE_PADDER_SHA3_EN
   task automatic test_sha3_512();
      logic [63:0] exp;
      rdy_pat[0] = 1'b1; rdy_len = 1;
      msg_words[0] = 64'hFFFF_FFFF_FFAA_BBCC;
      run_msg(2'b11, 1, 4'd3, 30);
      n_checks++; if (cap_n !== 9 || cap_done !== 1'b1) begin n_fails++;
         $display("FAIL sha3_count got n=%0d done=%b want 9 1", cap_n, cap_done); end
      for (int i = 0; i < 9; i++) begin
         exp = (i == 0) ? 64'h0000_0000_06AA_BBCC : (i == 8) ? 64'h8000_0000_0000_0000 : 64'h0;
         n_checks++; if (cap_data[i] !== exp || cap_ml[i] !== (i == 8)) begin n_fails++;
            $display("FAIL sha3_lane%0d got %h ml=%b want %h", i, cap_data[i], cap_ml[i], exp);
         end
      end
   endtask
`endif

   initial begin
      n_checks = 0; n_fails = 0;
      rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b1; rdy_pat[2] = 1'b1; rdy_pat[3] = 1'b1; rdy_len = 1;
      test_reset();
      test_shake128_empty();
      test_full_block();
      test_ds_final_byte();
      test_backpressure();
      test_reset_mid();
      test_clamp();
      test_back_to_back();
`ifdef SHAKE_PADDER_SHA3_EN
      test_sha3_512();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
